vga_frame_sequencer: RTL and testbench

- Owns VGA raster timing and schedules the game-logic update window.
- Generates full porch/sync timing, pixel coordinates and an active-video flag.
- Once per frame, at the start of vertical blank, issues a request/acknowledge handshake to the pong game-state logic so paddle and ball state change only while nothing is being drawn.
- Sits between the pixel-clock domain top level and the renderer/game logic.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_raster_counter.sv | 75 +++++++
 rtl/vga_frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared 640x480@60 timing defaults, the coordinate type and the
//            update-FSM state encoding for the VGA frame sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  // 640x480@60 default raster timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Raster coordinates are 12-bit unsigned, so totals must stay <= 4096
  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  // Update-FSM states (IDLE, REQ)
  typedef logic [0:0] upd_state_t;
  localparam upd_state_t UPD_IDLE = 1'b0;
  localparam upd_state_t UPD_REQ  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/vga_raster_counter.sv
// ============================================================================
// Module   : vga_raster_counter
// Purpose  : Column/row raster counters with enable and wrap. Also exposes
//            the position that will be shown after this clock and strobes
//            for "next position starts a line" and "next position is 0,0".
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_raster_counter
  import vga_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t col,
  output coord_t row,
  output coord_t col_nxt,
  output coord_t row_nxt,
  output logic   line_wrap,
  output logic   frame_wrap
);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  logic   started_q, started_d;
  coord_t col_q, col_d;
  coord_t row_q, row_d;

  // Next position: the first enabled clock after reset presents 0,0 without
  // advancing; every later enabled clock steps one pixel with wrap.
  always_comb begin
    started_d = started_q;
    col_d     = col_q;
    row_d     = row_q;
    if (en) begin
      started_d = 1'b1;
      if (started_q) begin
        if (col_q == H_LAST) begin
          col_d = '0;
          row_d = (row_q == V_LAST) ? '0 : row_q + 12'd1;
        end else begin
          col_d = col_q + 12'd1;
        end
      end
    end
  end

  // Counter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      started_q <= started_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign col_nxt    = col_d;
  assign row_nxt    = row_d;
  assign line_wrap  = en && (col_d == '0);
  assign frame_wrap = line_wrap && (row_d == '0);

endmodule

`default_nettype wire

// File: rtl/vga_frame_sequencer.sv
// ============================================================================
// Module   : vga_frame_sequencer
// Purpose  : VGA raster timing (sync, active, coordinates, frame pulse) plus a
//            once-per-frame game-update request/acknowledge issued at the
//            start of vertical blank, with overrun detection.
// Options  : VGA_FRAME_SEQ_STATS_EN adds a saturating 16-bit overrun_count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] col,
  output logic [11:0] row,
  output logic        active,
  output logic        h_sync,
  output logic        v_sync,
  output logic        frame_start,
  output logic        upd_req,
  input  logic        upd_ack,
  output logic        overrun
`ifdef VGA_FRAME_SEQ_STATS_EN
  ,
  output logic [15:0] overrun_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t H_SS_C  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SE_C  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
  localparam coord_t V_SS_C  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SE_C  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t     col_nxt, row_nxt;
  logic       line_wrap, frame_wrap;

  logic       active_q, active_d;
  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic       frame_start_q, frame_start_d;
  logic       overrun_q, overrun_d;
  upd_state_t state_q, state_d;

  vga_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .col        (col),
    .row        (row),
    .col_nxt    (col_nxt),
    .row_nxt    (row_nxt),
    .line_wrap  (line_wrap),
    .frame_wrap (frame_wrap)
  );

  // Decode raster flags from the position being loaded so they line up with
  // the registered col/row; update FSM runs every cycle regardless of en.
  always_comb begin
    active_d      = active_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    frame_start_d = 1'b0;
    overrun_d     = 1'b0;
    state_d       = state_q;

    if (en) begin
      active_d      = (col_nxt < H_ACT_C) && (row_nxt < V_ACT_C);
      h_sync_d      = !((col_nxt >= H_SS_C) && (col_nxt < H_SE_C));
      v_sync_d      = !((row_nxt >= V_SS_C) && (row_nxt < V_SE_C));
      frame_start_d = frame_wrap;
    end

    case (state_q)
      UPD_IDLE: begin
        if (line_wrap && (row_nxt == V_ACT_C)) begin
          state_d = UPD_REQ;
        end
      end
      UPD_REQ: begin
        // An ack on the wrap cycle still counts as on time.
        if (upd_ack) begin
          state_d = UPD_IDLE;
        end else if (frame_wrap) begin
          overrun_d = 1'b1;
          state_d   = UPD_IDLE;
        end
      end
      default: state_d = UPD_IDLE;
    endcase
  end

  // Output and FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q      <= 1'b0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      state_q       <= UPD_IDLE;
    end else begin
      active_q      <= active_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      state_q       <= state_d;
    end
  end

  assign active      = active_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;
  assign upd_req     = (state_q == UPD_REQ);

`ifdef VGA_FRAME_SEQ_STATS_EN
  logic [15:0] overrun_count_q, overrun_count_d;

  // Saturating overrun counter, bumped together with the overrun pulse
  always_comb begin
    overrun_count_d = overrun_count_q;
    if (overrun_d && (overrun_count_q != 16'hFFFF)) begin
      overrun_count_d = overrun_count_q + 16'd1;
    end
  end

  // Overrun counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_count_q <= '0;
    end else begin
      overrun_count_q <= overrun_count_d;
    end
  end

  assign overrun_count = overrun_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_sequencer.sv
// ============================================================================
// Module   : tb_vga_frame_sequencer
// Purpose  : Randomized scoreboard bench for vga_frame_sequencer. A reduced
//            raster geometry is used so many frames fit in a short run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_frame_sequencer;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int N_CYC = 6000;

  logic        clk = 1'b0;
  logic        rst, en, upd_ack;
  logic [11:0] col, row;
  logic        active, h_sync, v_sync, frame_start, upd_req, overrun;
`ifdef VGA_FRAME_SEQ_STATS_EN
  logic [15:0] overrun_count;
  int          cnt_q[$];
`endif

  always #5 clk = ~clk;

  vga_frame_sequencer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .col         (col),
    .row         (row),
    .active      (active),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .frame_start (frame_start),
    .upd_req     (upd_req),
    .upd_ack     (upd_ack),
    .overrun     (overrun)
`ifdef VGA_FRAME_SEQ_STATS_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  typedef struct packed {
    logic [11:0] col;
    logic [11:0] row;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        req;
    logic        ov;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: linear pixel index within the frame plus request flag
  bit m_started, m_req, m_fs, m_ov;
  int m_pos, m_cnt;

  function automatic vec_t reset_vec();
    vec_t v;
    v = '0;
    v.hs = 1'b1;
    v.vs = 1'b1;
    return v;
  endfunction

  function automatic vec_t model_out();
    vec_t v;
    int c, r;
    c = m_pos % HT;
    r = m_pos / HT;
    v = reset_vec();
    v.col = 12'(c);
    v.row = 12'(r);
    if (m_started) begin
      v.act = (c < HA) && (r < VA);
      v.hs  = !((c >= HA + HF) && (c < HA + HF + HS));
      v.vs  = !((r >= VA + VF) && (r < VA + VF + VS));
    end
    v.fs  = m_fs;
    v.req = m_req;
    v.ov  = m_ov;
    return v;
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit a);
    bit wrap;
    if (r) begin
      m_started = 0; m_pos = 0; m_req = 0; m_fs = 0; m_ov = 0; m_cnt = 0;
      return;
    end
    wrap = 0; m_fs = 0; m_ov = 0;
    if (e) begin
      if (m_started) m_pos = (m_pos + 1) % FT;
      m_started = 1;
      wrap = (m_pos == 0);
      m_fs = wrap;
    end
    if (m_req) begin
      if (a) m_req = 0;
      else if (wrap) begin
        m_req = 0;
        m_ov  = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (e && m_pos == VA * HT) begin
      m_req = 1;
    end
  endfunction

  // Stimulus: random en/ack, one 37-cycle en hold, one reset during REQ.
  // Ack policy rotates per request: delayed ack, never ack, ack on wrap.
  initial begin
    bit r, e, a, prev_req, hold_done, rst_done;
    int hold, mode, delay, waited, n_req;
    rst = 1'b1; en = 1'b0; upd_ack = 1'b0;
    model_step(1, 0, 0);
    hold = 0; hold_done = 0; rst_done = 0;
    mode = 0; delay = 5; waited = 0; n_req = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk); #1;
      r = (cyc < 3);
      if (!r && !rst_done && cyc > 1500 && m_req && (m_pos / HT) == VA + 3) begin
        r = 1; rst_done = 1;
      end
      if (hold > 0) begin
        e = 0; hold--;
      end else if (!hold_done && m_started && m_pos == 3 * HT + 4) begin
        e = 0; hold = 36; hold_done = 1;
      end else begin
        e = ($urandom_range(0, 7) != 0);
      end
      if (m_req) begin
        case (mode)
          0:       a = (waited == delay);
          1:       a = 0;
          default: a = e && (m_pos == FT - 1);
        endcase
        waited++;
      end else begin
        a = ($urandom_range(0, 15) == 0);
      end
      rst = r; en = e; upd_ack = a;
      exp_q.push_back(r ? reset_vec() : model_out());
`ifdef VGA_FRAME_SEQ_STATS_EN
      cnt_q.push_back(r ? 0 : m_cnt);
`endif
      prev_req = m_req;
      model_step(r, e, a);
      if (!prev_req && m_req) begin
        mode   = n_req % 3;
        delay  = (n_req == 0) ? 5 : $urandom_range(0, 10);
        waited = 0;
        n_req++;
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Monitor: pops one expectation per cycle, away from the active edge
  always @(negedge clk) begin
    vec_t x, got;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      got.col = col; got.row = row; got.act = active; got.hs = h_sync;
      got.vs = v_sync; got.fs = frame_start; got.req = upd_req; got.ov = overrun;
      n_vec++;
      if (got !== x) begin
        n_bad++;
        $display("FAIL raster @%0t: got col=%0d row=%0d act/hs/vs/fs/req/ov=%b%b%b%b%b%b, required col=%0d row=%0d act/hs/vs/fs/req/ov=%b%b%b%b%b%b",
                 $time, got.col, got.row, got.act, got.hs, got.vs, got.fs, got.req, got.ov,
                 x.col, x.row, x.act, x.hs, x.vs, x.fs, x.req, x.ov);
      end
`ifdef VGA_FRAME_SEQ_STATS_EN
      begin
        int xc;
        xc = cnt_q.pop_front();
        n_vec++;
        if (overrun_count !== 16'(xc)) begin
          n_bad++;
          $display("FAIL overrun_count @%0t: got %0d, required %0d", $time, overrun_count, xc);
        end
      end
`endif
    end
  end

endmodule

`default_nettype wire
